// File: rtl/player_controller_if.sv
// Button/frame inputs and registered square position/pulse outputs of player_controller.
// The controller uses the slave modport; whatever drives buttons and frame_start uses master.
interface player_controller_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       frame_start;
    logic [4:0] sq_col;
    logic [3:0] sq_row;
    logic [9:0] sq_x;
    logic [9:0] sq_y;
    logic       move_done;
    logic       blocked;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, frame_start,
        input  sq_col, sq_row, sq_x, sq_y, move_done, blocked
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, frame_start,
        output sq_col, sq_row, sq_x, sq_y, move_done, blocked
    );
endinterface

// File: rtl/player_controller.sv
// player_controller: debounced push-buttons -> grid cell of the player square, at most one move per frame.
// Define PLAYER_WRAP_EN to wrap moves around the grid edges instead of rejecting them.
//
// state  | meaning
// IDLE   | waiting for a debounced press
// ARMED  | direction latched, waiting for frame_start
// UPDATE | one cycle: commit or reject the latched move
module player_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int GRID_SIZE       = 32,
    parameter int GRID_COLS       = 20,
    parameter int GRID_ROWS       = 15,
    parameter int START_COL       = 10,
    parameter int START_ROW       = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    player_controller_if.slave bus
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SHIFT = $clog2(GRID_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] COL_LAST  = 5'(GRID_COLS - 1);
    localparam logic [3:0] ROW_LAST  = 4'(GRID_ROWS - 1);
    localparam logic [4:0] COL_RESET = 5'(START_COL);
    localparam logic [3:0] ROW_RESET = 4'(START_ROW);
    localparam logic [9:0] X_RESET   = 10'(START_COL * GRID_SIZE);
    localparam logic [9:0] Y_RESET   = 10'(START_ROW * GRID_SIZE);

    typedef enum logic [1:0] {IDLE, ARMED, UPDATE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    // bit order everywhere: [0]=up [1]=down [2]=left [3]=right
    logic [3:0]       btn_raw;
    logic [3:0]       sync_1;
    logic [3:0]       sync_2;
    logic [3:0]       stable;
    logic [3:0]       press;
    logic [CNT_W-1:0] deb_cnt [4];

    state_t     state;
    state_t     state_nxt;
    dir_t       dir_q;
    dir_t       dir_sel;
    logic       load_dir;
    logic       commit;
    logic       reject;
    logic       in_range;
    logic [4:0] tgt_col;
    logic [3:0] tgt_row;
    logic [4:0] col_q;
    logic [3:0] row_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       move_done_q;
    logic       blocked_q;

    assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    stable[i]  <= sync_2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is flagged in the same cycle the stable level is about to rise.
    always_comb begin
        press = '0;
        for (int i = 0; i < 4; i++) begin
            press[i] = sync_2[i] & ~stable[i] & (deb_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (press != '0)      state_nxt = ARMED;
            ARMED:   if (bus.frame_start)  state_nxt = UPDATE;
            UPDATE:                        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tgt_col  = col_q;
        tgt_row  = row_q;
        in_range = 1'b1;
        case (dir_q)
            DIR_UP: begin
                if (row_q == 4'd0) begin
`ifdef PLAYER_WRAP_EN
                    tgt_row = ROW_LAST;
`else
                    in_range = 1'b0;
`endif
                end else begin
                    tgt_row = row_q - 4'd1;
                end
            end
            DIR_DOWN: begin
                if (row_q == ROW_LAST) begin
`ifdef PLAYER_WRAP_EN
                    tgt_row = 4'd0;
`else
                    in_range = 1'b0;
`endif
                end else begin
                    tgt_row = row_q + 4'd1;
                end
            end
            DIR_LEFT: begin
                if (col_q == 5'd0) begin
`ifdef PLAYER_WRAP_EN
                    tgt_col = COL_LAST;
`else
                    in_range = 1'b0;
`endif
                end else begin
                    tgt_col = col_q - 5'd1;
                end
            end
            DIR_RIGHT: begin
                if (col_q == COL_LAST) begin
`ifdef PLAYER_WRAP_EN
                    tgt_col = 5'd0;
`else
                    in_range = 1'b0;
`endif
                end else begin
                    tgt_col = col_q + 5'd1;
                end
            end
            default: in_range = 1'b0;
        endcase

        if (press[0])      dir_sel = DIR_UP;
        else if (press[1]) dir_sel = DIR_DOWN;
        else if (press[2]) dir_sel = DIR_LEFT;
        else               dir_sel = DIR_RIGHT;

        load_dir = (state == IDLE) && (press != '0);
        commit   = (state == UPDATE) && in_range;
        reject   = (state == UPDATE) && !in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= DIR_UP;
            col_q       <= COL_RESET;
            row_q       <= ROW_RESET;
            x_q         <= X_RESET;
            y_q         <= Y_RESET;
            move_done_q <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            if (load_dir) dir_q <= dir_sel;
            move_done_q <= commit;
            blocked_q   <= reject;
            if (commit) begin
                col_q <= tgt_col;
                row_q <= tgt_row;
                x_q   <= 10'(tgt_col) << SHIFT;
                y_q   <= 10'(tgt_row) << SHIFT;
            end
        end
    end

    assign bus.sq_col    = col_q;
    assign bus.sq_row    = row_q;
    assign bus.sq_x      = x_q;
    assign bus.sq_y      = y_q;
    assign bus.move_done = move_done_q;
    assign bus.blocked   = blocked_q;
endmodule

// File: doc/player_controller.md
Name: player_controller

Overview:
Upstream stage of the display path. Turns four raw push-buttons into a grid-cell position for the player square. Each input is synchronised, debounced and edge-detected. At most one move is committed per video frame, on the frame_start pulse. The registered cell and pixel coordinates feed the square drawer, so the square never tears mid-frame.

Parameters:
DEBOUNCE_CYCLES, 250000, stable cycles needed to accept a button level change (10 ms at 25 MHz)
GRID_SIZE, 32, cell edge in pixels; power of two
GRID_COLS, 20, cells per row (640/GRID_SIZE); at most 32
GRID_ROWS, 15, cells per column (480/GRID_SIZE); at most 16
START_COL, 10, reset column
START_ROW, 14, reset row (bottom row)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
btn_up  in  1  raw button, active-high, asynchronous to clk
btn_down  in  1  raw button, active-high
btn_left  in  1  raw button, active-high
btn_right  in  1  raw button, active-high
frame_start  in  1  one-clk pulse from the VGA timing when h/v counters are both 0
sq_col  out  5  current column, 0..GRID_COLS-1
sq_row  out  4  current row, 0..GRID_ROWS-1 (0 = top)
sq_x  out  10  sq_col*GRID_SIZE, left pixel of square
sq_y  out  10  sq_row*GRID_SIZE, top pixel of square
move_done  out  1  one-clk pulse: position changed
blocked  out  1  one-clk pulse: move rejected at grid edge

Behaviour:
- Interface: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - sq_col=START_COL, sq_row=START_ROW; sq_x and sq_y match these.
  - move_done=0, blocked=0.
  - Synchronisers, stable levels and debounce counters all 0.
  - State IDLE; latched direction cleared.
- Synchroniser: 2 flops per button.
- Debounce, per button:
  - If the sync level equals the stable level, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the sync level and the counter clears.
  - Any bounce back to the stable level before then restarts the count.
- Edge detect: a press is a stable-level 0->1 transition. Releases are ignored.
- FSM states: IDLE, ARMED, UPDATE.
  - IDLE: on any press, latch the direction and go to ARMED.
  - IDLE, multiple presses in the same cycle: priority up > down > left > right.
  - IDLE, press in the same cycle as frame_start: goes to ARMED only. The move commits on the next frame_start.
  - ARMED: wait for frame_start, then go to UPDATE. Further presses in ARMED are dropped; there is a single-entry buffer.
  - UPDATE (one cycle): compute the target cell.
    - up = row-1, down = row+1, left = col-1, right = col+1.
    - If the target is in range, register sq_col, sq_row, sq_x and sq_y together and pulse move_done.
    - Otherwise leave the position unchanged and pulse blocked.
    - Return to IDLE. Presses during UPDATE are dropped.
- Latency: frame_start sampled on edge E0 (state ARMED). The new position and the pulse are visible after E1 and last exactly one cycle.
- Arithmetic:
  - sq_x = sq_col << log2(GRID_SIZE), zero-extended to 10 bits; sq_y likewise.
  - Range checks are done before modifying the registers, so there is no underflow wrap.
- Reset asserted mid-operation: immediate return to reset values. Any latched move is discarded and does not commit on a later frame_start.
- frame_start in IDLE or UPDATE: no effect.

Optional Feature:
PLAYER_WRAP_EN.
- Defined: moves wrap around the grid edges, and blocked is tied to 0.
  - left from col 0 -> GRID_COLS-1; right from GRID_COLS-1 -> 0.
  - up from row 0 -> GRID_ROWS-1; down from GRID_ROWS-1 -> 0.
- Undefined: out-of-range moves clamp (position unchanged) and pulse blocked.

Test Plan:
1. Reset (DEBOUNCE_CYCLES=4 in all tests): hold rst_n low, then release -> sq_col=10, sq_row=14, sq_x=320, sq_y=448, move_done=0, blocked=0.
2. btn_up high for 10 cycles, then a frame_start pulse -> sq_row=13, sq_y=416; move_done high for exactly one cycle, one edge after frame_start is sampled; sq_col unchanged.
3. btn_right toggles every 2 cycles for 20 cycles then stays low, then frame_start -> no press is accepted; position unchanged; no pulses.
4. At row 14, press down, then frame_start -> blocked pulses once, sq_row stays 14. With PLAYER_WRAP_EN: sq_row=0, sq_y=0, move_done pulses.
5. Two presses before one frame_start: up, then 10 cycles later left -> only up commits (row 13, col 10); a second frame_start causes no further move.
6. Two cases:
   - up and left debounced in the same cycle, then frame_start -> row 13, col 10.
   - rst_n pulsed low while ARMED, then frame_start -> position stays 10/14, no pulses.
